bit_scatter_16: RTL and testbench
=================================

BIT_SCATTER_16 -- requirements
Module: bit_scatter_16

Interface
REQ-001 Parameter RESET_VAL, default 16'h0000, SHALL be the data-register value loaded on reset and on clear.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-low reset (0 = in reset).
REQ-004 clear  input  1  SHALL be a synchronous, active-high flush of the collection in progress.
REQ-005 mode  input  1  SHALL select the beat target: 0 = addressed (wr_sel), 1 = sequential (internal pointer).
REQ-006 wr_sel  input  4  SHALL be the bit index written in addressed mode.
REQ-007 in_bit  input  1  SHALL be the data bit of the current beat.
REQ-008 in_valid  input  1  SHALL be asserted by the source when in_bit (and wr_sel) are valid.
REQ-009 in_ready  output  1  SHALL indicate the block accepts a beat this cycle.
REQ-010 out_data  output  16  SHALL be the data register, continuously driven.
REQ-011 out_valid  output  1  SHALL indicate a complete 16-bit word is held.
REQ-012 out_ready  input  1  SHALL be asserted by the sink to consume the word.

Function
REQ-013 A beat SHALL be accepted exactly when in_valid && in_ready is high at a rising edge.
REQ-014 The block SHALL implement two states, FILL (in_ready=1, out_valid=0) and FULL (in_ready=0, out_valid=1).
REQ-015 Addressed-mode accept SHALL set data[wr_sel] <= in_bit and mask[wr_sel] <= 1, all other data bits holding.
REQ-016 Sequential-mode accept SHALL set data[ptr] <= in_bit and mask[ptr] <= 1, then ptr <= ptr+1 mod 16 (15 wraps to 0).
REQ-017 ptr SHALL change only on sequential-mode accepts; mode SHALL be sampled per beat and may change between beats.
REQ-018 Rewriting an already-masked bit SHALL overwrite the data bit and leave the mask unchanged.
REQ-019 FILL -> FULL SHALL occur on the accept that makes the mask 16'hFFFF; out_valid rises the following cycle.
REQ-020 In FULL, out_data SHALL be stable and in_valid SHALL be ignored.
REQ-021 FULL -> FILL SHALL occur on out_valid && out_ready, clearing mask and ptr to 0 while data holds; in_ready rises the next cycle.
REQ-022 Minimum throughput SHALL be one word per 17 cycles (16 beats + 1 handoff).
REQ-023 clear=1 SHALL override all other inputs: next state FILL, data=RESET_VAL, mask=0, ptr=0, with no beat accepted and no word consumed that cycle.

Reset
REQ-024 While reset=0, the block SHALL asynchronously force state FILL, data=RESET_VAL, mask=0, ptr=0.
REQ-025 Reset values SHALL be: out_data=RESET_VAL, out_valid=0, in_ready=1 (in_ready may be 0 while reset is asserted).
REQ-026 Reset asserted mid-collection or in FULL SHALL discard partial and pending words.

Configuration
REQ-027 With macro BIT_SCATTER_16_PARITY_EN defined, the module SHALL have an extra output out_parity (1 bit) equal to the XOR of out_data, valid whenever out_valid=1.
REQ-028 With BIT_SCATTER_16_PARITY_EN undefined, out_parity SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 Sequential: reset, mode=1, 16 beats of bits for 16'hA5C3 (bit0 first), out_ready=0 -> out_valid=1 the cycle after beat 16, out_data=16'hA5C3, in_ready=0.
REQ-030 Addressed: mode=0, wr_sel 15 down to 0 with in_bit=wr_sel[0] -> out_data=16'hAAAA; a 17th in_valid beat is not accepted.
REQ-031 Overwrite: addressed beats write bit3=1 then bit3=0, then the other 15 bits with 0 -> FULL only after beat 17, out_data=16'h0000.
REQ-032 Handoff: in FULL, assert out_ready for 1 cycle -> out_valid=0 and in_ready=1 next cycle; next sequential beat writes bit 0.
REQ-033 Clear/reset: after 7 beats, pulse clear -> mask/ptr=0, out_data=RESET_VAL; repeat with reset=0 mid-FULL -> out_valid=0 immediately, without waiting for a clk edge.
REQ-034 Parity (macro defined): word 16'h0007 -> out_parity=1; word 16'h000F -> out_parity=0.

Source files
------------

// File: rtl/bit_scatter_16.sv
// bit_scatter_16: collects 16 single-bit beats (addressed or sequential) into a word; define BIT_SCATTER_16_PARITY_EN to add out_parity
module bit_scatter_16 #(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        mode,
  input  logic [3:0]  wr_sel,
  input  logic        in_bit,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
`ifdef BIT_SCATTER_16_PARITY_EN
  ,
  output logic        out_parity
`endif
);
  typedef enum logic {FILL, FULL} state_t;
  state_t state, state_n;
  logic [15:0] data, data_n, mask, mask_n, mask_set;
  logic [3:0] ptr, ptr_n, idx;
  logic acc;
  assign in_ready = state == FILL;
  assign out_valid = state == FULL;
  assign out_data = data;
  assign acc = in_valid && in_ready;
  assign idx = mode ? ptr : wr_sel;
  assign mask_set = mask | (16'h0001 << idx);
`ifdef BIT_SCATTER_16_PARITY_EN
  assign out_parity = ^data;
`endif
  // next state: clear wins, then a beat in FILL, then the handoff in FULL
  always_comb begin
    state_n = state;
    data_n = data;
    mask_n = mask;
    ptr_n = ptr;
    if (clear) begin
      state_n = FILL;
      data_n = RESET_VAL;
      mask_n = '0;
      ptr_n = '0;
    end else if (acc) begin
      data_n[idx] = in_bit;
      mask_n = mask_set;
      ptr_n = mode ? ptr + 4'd1 : ptr;
      state_n = &mask_set ? FULL : FILL;
    end else if (out_valid && out_ready) begin
      state_n = FILL;
      mask_n = '0;
      ptr_n = '0;
    end
  end
  // state registers; reset discards any partial or pending word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FILL;
      data <= RESET_VAL;
      mask <= '0;
      ptr <= '0;
    end else begin
      state <= state_n;
      data <= data_n;
      mask <= mask_n;
      ptr <= ptr_n;
    end
  end
endmodule

// File: tb/tb_bit_scatter_16.sv
// tb_bit_scatter_16: randomized and directed self-check of bit_scatter_16 against a behavioural model
module tb_bit_scatter_16;
  localparam logic [15:0] RV = 16'h5A3C;
  logic clk = 0, reset = 0, clear = 0, mode = 0, in_bit = 0, in_valid = 0, out_ready = 0;
  logic [3:0] wr_sel = 0;
  logic in_ready, out_valid;
  logic [15:0] out_data;
`ifdef BIT_SCATTER_16_PARITY_EN
  logic out_parity;
`endif
  int checks = 0, failures = 0;
  bit md[16];
  bit mm[16];
  int mp;
  bit mf;

  bit_scatter_16 #(.RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .clear(clear), .mode(mode), .wr_sel(wr_sel),
    .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef BIT_SCATTER_16_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mword();
    logic [15:0] w = '0;
    for (int i = 0; i < 16; i++) w[i] = md[i];
    return w;
  endfunction

  function automatic int mcount();
    int n = 0;
    for (int i = 0; i < 16; i++) n += mm[i];
    return n;
  endfunction

  task automatic mflush(input bit to_rv);
    for (int i = 0; i < 16; i++) begin
      mm[i] = 0;
      if (to_rv) md[i] = RV[i];
    end
    mp = 0;
    mf = 0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, "_data"}, out_data, mword());
    chk({tag, "_ovalid"}, {15'd0, out_valid}, {15'd0, mf});
    chk({tag, "_iready"}, {15'd0, in_ready}, {15'd0, !mf});
`ifdef BIT_SCATTER_16_PARITY_EN
    if (mf) chk({tag, "_parity"}, {15'd0, out_parity}, {15'd0, ^mword()});
`endif
  endtask

  task automatic cyc(input string tag, input bit v, input bit m, input int sel, input bit b,
                     input bit rdy, input bit clr);
    int idx;
    in_valid = v; mode = m; wr_sel = 4'(sel); in_bit = b; out_ready = rdy; clear = clr;
    if (clr) mflush(1);
    else if (!mf && v) begin
      idx = m ? mp : sel;
      md[idx] = b;
      mm[idx] = 1;
      if (m) mp = (mp + 1) % 16;
      if (mcount() == 16) mf = 1;
    end else if (mf && rdy) mflush(0);
    @(posedge clk);
    #1;
    cmp_all(tag);
  endtask

  task automatic load_addr(input logic [15:0] w);
    for (int i = 0; i < 16; i++) cyc("load", 1, 0, i, w[i], 0, 0);
  endtask

  initial begin
    logic [15:0] pat;
    mflush(1);
    #12;
    chk("rst_data", out_data, RV);
    chk("rst_ovalid", {15'd0, out_valid}, 16'd0);
    @(posedge clk); #1;
    reset = 1;
    cmp_all("rst_release");
    pat = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      cyc("seq", 1, 1, 0, pat[i], 0, 0);
      chk("seq_ovalid_timing", {15'd0, out_valid}, {15'd0, i == 15});
    end
    chk("seq_word", out_data, 16'hA5C3);
    chk("seq_iready", {15'd0, in_ready}, 16'd0);
    cyc("full_hold", 1, 1, 0, 0, 0, 0);
    chk("full_hold_word", out_data, 16'hA5C3);
    cyc("handoff", 0, 0, 0, 0, 1, 0);
    chk("handoff_ovalid", {15'd0, out_valid}, 16'd0);
    chk("handoff_iready", {15'd0, in_ready}, 16'd1);
    cyc("seq_after", 1, 1, 0, 0, 0, 0);
    chk("seq_after_bit0", {15'd0, out_data[0]}, 16'd0);
    cyc("clr_a", 0, 0, 0, 0, 0, 1);
    for (int s = 15; s >= 0; s--) cyc("addr", 1, 0, s, s[0], 0, 0);
    chk("addr_word", out_data, 16'hAAAA);
    cyc("addr_17th", 1, 0, 0, 1, 0, 0);
    chk("addr_17th_word", out_data, 16'hAAAA);
    cyc("handoff2", 0, 0, 0, 0, 1, 0);
    cyc("ow1", 1, 0, 3, 1, 0, 0);
    cyc("ow2", 1, 0, 3, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 3) continue;
      cyc("ow_rest", 1, 0, i, 0, 0, 0);
      chk("ow_not_full", {15'd0, out_valid}, {15'd0, i == 15});
    end
    chk("ow_word", out_data, 16'h0000);
    cyc("handoff3", 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) cyc("pre_clr", 1, 1, 0, 1, 0, 0);
    cyc("clr", 1, 1, 0, 1, 1, 1);
    chk("clr_word", out_data, RV);
    pat = 16'h3C96;
    for (int i = 0; i < 16; i++) cyc("post_clr", 1, 1, 0, pat[i], 0, 0);
    chk("post_clr_word", out_data, 16'h3C96);
    chk("post_clr_full", {15'd0, out_valid}, 16'd1);
    reset = 0;
    mflush(1);
    #1;
    chk("async_rst_ovalid", {15'd0, out_valid}, 16'd0);
    chk("async_rst_data", out_data, RV);
    @(posedge clk); #1;
    reset = 1;
    cmp_all("rst2_release");
`ifdef BIT_SCATTER_16_PARITY_EN
    load_addr(16'h0007);
    chk("par_7", {15'd0, out_parity}, 16'd1);
    cyc("par_ho", 0, 0, 0, 0, 1, 0);
    load_addr(16'h000F);
    chk("par_f", {15'd0, out_parity}, 16'd0);
    cyc("par_ho2", 0, 0, 0, 0, 1, 0);
`endif
    for (int i = 0; i < 600; i++)
      cyc("rand", $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15), 1'($urandom),
          $urandom_range(0, 3) == 0, $urandom_range(0, 60) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
